// File: rtl/reg_file_param_if.sv
// Register file bus: decode-side read ports, writeback-side write port,
// clear request/busy handshake and the debug read port.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read1;
    logic [ADDR_W-1:0] read2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              writeEna;
    logic              clear_req;
    logic              busy;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    // The core (or bench) drives addresses, write data and requests.
    modport master (
        output read1, read2, writeReg, writeData, writeEna, clear_req, dbg_addr,
        input  data1, data2, busy, dbg_data
    );

    // The register file answers with read data and sweep status.
    modport slave (
        input  read1, read2, writeReg, writeData, writeEna, clear_req, dbg_addr,
        output data1, data2, busy, dbg_data
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports with optional
// write-to-read forwarding, one synchronous write port, an optional hardwired
// zero entry, a sequenced clear sweep (one entry per cycle) and a debug port.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic             clock,
    input logic             reset,
    reg_file_param_if.slave rf
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              wr_allowed;
    logic              hit1;
    logic              hit2;

    // True when the address falls on the hardwired zero entry.
    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write lands only in IDLE, only with a definite enable, never on the zero entry.
    always_comb begin
        wr_allowed = (state_q == IDLE) && (rf.writeEna == 1'b1) && !is_zero_addr(rf.writeReg);
        hit1       = (BYPASS != 0) && wr_allowed && (rf.writeReg == rf.read1);
        hit2       = (BYPASS != 0) && wr_allowed && (rf.writeReg == rf.read2);
    end

    // State register for the clear sweep controller and its entry index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a request starts the sweep; the last entry ends it and rewinds the index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (rf.clear_req == 1'b1) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Next array contents: a normal write in IDLE, or zeroing one entry per cycle in CLEAR.
    always_comb begin
        mem_d = mem_q;
        if (wr_allowed) begin
            mem_d[rf.writeReg] = rf.writeData;
        end
        if (state_q == CLEAR) begin
            mem_d[idx_q] = '0;
        end
    end

    // Storage array; reset wipes every entry at once and aborts any sweep.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Output logic: busy flag, forwarded read ports and the plain debug port.
    always_comb begin
        rf.busy = (state_q == CLEAR);

        if (hit1) begin
            rf.data1 = rf.writeData;
        end else if (is_zero_addr(rf.read1)) begin
            rf.data1 = '0;
        end else begin
            rf.data1 = mem_q[rf.read1];
        end

        if (hit2) begin
            rf.data2 = rf.writeData;
        end else if (is_zero_addr(rf.read2)) begin
            rf.data2 = '0;
        end else begin
            rf.data2 = mem_q[rf.read2];
        end

        if (is_zero_addr(rf.dbg_addr)) begin
            rf.dbg_data = '0;
        end else begin
            rf.dbg_data = mem_q[rf.dbg_addr];
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a default instance (32x32, zero entry, forwarding)
// and a small one (8x16, no zero entry), both compared against an array model.
module tb_reg_file_param;
    logic clock = 1'b0;
    logic reset = 1'b1;

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .rf    (ifa)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .rf    (ifb)
    );

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] model [2][32];
    int          sweep [2];
    int          depth [2] = '{32, 8};
    bit          zr    [2] = '{1'b1, 1'b0};

    bit          in_we  [2];
    bit          in_clr [2];
    int          in_wr  [2];
    int          in_r1  [2];
    int          in_r2  [2];
    int          in_dbg [2];
    logic [31:0] in_wd  [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            sweep[u] = -1;
            for (int a = 0; a < 32; a++) model[u][a] = '0;
        end
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            in_we[u] = 0; in_clr[u] = 0; in_wr[u] = 0; in_wd[u] = '0;
            in_r1[u] = 0; in_r2[u] = 0; in_dbg[u] = 0;
        end
    endtask

    // One clock edge worth of behaviour: a sweep clears one entry, otherwise writes land.
    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            if (sweep[u] < 0) begin
                if (in_we[u] && !(zr[u] && in_wr[u] == 0)) model[u][in_wr[u]] = in_wd[u];
                if (in_clr[u]) sweep[u] = 0;
            end else begin
                model[u][sweep[u]] = '0;
                sweep[u]++;
                if (sweep[u] == depth[u]) sweep[u] = -1;
            end
        end
    endtask

    function automatic logic [31:0] exp_read(int u, int a, bit fwd);
        if (zr[u] && a == 0) return '0;
        if (fwd && sweep[u] < 0 && in_we[u] && in_wr[u] == a) return in_wd[u];
        return model[u][a];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        ifa.writeEna  = in_we[0];
        ifa.clear_req = in_clr[0];
        ifa.writeReg  = 5'(in_wr[0]);
        ifa.writeData = in_wd[0];
        ifa.read1     = 5'(in_r1[0]);
        ifa.read2     = 5'(in_r2[0]);
        ifa.dbg_addr  = 5'(in_dbg[0]);
        ifb.writeEna  = in_we[1];
        ifb.clear_req = in_clr[1];
        ifb.writeReg  = 3'(in_wr[1]);
        ifb.writeData = in_wd[1][15:0];
        ifb.read1     = 3'(in_r1[1]);
        ifb.read2     = 3'(in_r2[1]);
        ifb.dbg_addr  = 3'(in_dbg[1]);
        #1;
    endtask

    task automatic checkOutput();
        check("a.data1", ifa.data1, exp_read(0, in_r1[0], 1));
        check("a.data2", ifa.data2, exp_read(0, in_r2[0], 1));
        check("a.dbg",   ifa.dbg_data, exp_read(0, in_dbg[0], 0));
        check("a.busy",  {31'b0, ifa.busy}, 32'(sweep[0] >= 0));
        check("b.data1", {16'b0, ifb.data1}, exp_read(1, in_r1[1], 1));
        check("b.data2", {16'b0, ifb.data2}, exp_read(1, in_r2[1], 1));
        check("b.dbg",   {16'b0, ifb.dbg_data}, exp_read(1, in_dbg[1], 0));
        check("b.busy",  {31'b0, ifb.busy}, 32'(sweep[1] >= 0));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic cycle();
        applyStimulus();
        checkOutput();
        tick();
    endtask

    task automatic read_all_zero(int u, string tag);
        for (int a = 0; a < depth[u]; a++) begin
            in_r1[u] = a; in_r2[u] = a; in_dbg[u] = a;
            applyStimulus();
            checkOutput();
            if (u == 0) check(tag, ifa.data1, 32'h0);
            else        check(tag, {16'b0, ifb.data1}, 32'h0);
        end
    endtask

    // Directed scenarios followed by a randomized run on both instances.
    initial begin
        int busy_cnt;
        model_reset();
        idle_inputs();
        applyStimulus();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state on addresses 0, 5, 31.
        in_r1[0] = 0; in_r2[0] = 5; in_dbg[0] = 31;
        applyStimulus();
        check("rst.data2", ifa.data2, 32'h0);
        check("rst.busy", {31'b0, ifa.busy}, 32'h0);
        cycle();
        in_r1[0] = 31; in_r2[0] = 0; in_dbg[0] = 5;
        cycle();

        // Plain write, then a write to the zero entry.
        in_we[0] = 1; in_wr[0] = 8; in_wd[0] = 32'hDEADBEEF; in_r1[0] = 8;
        cycle();
        in_we[0] = 0;
        applyStimulus();
        check("wr.data1", ifa.data1, 32'hDEADBEEF);
        cycle();
        in_we[0] = 1; in_wr[0] = 0; in_wd[0] = 32'h12345678; in_r2[0] = 0;
        cycle();
        in_we[0] = 0;
        applyStimulus();
        check("zero.data2", ifa.data2, 32'h0);
        cycle();

        // Same-cycle forwarding on both ports; debug shows the stored value.
        in_we[0] = 1; in_wr[0] = 9; in_wd[0] = 32'hA5A5A5A5;
        in_r1[0] = 9; in_r2[0] = 9; in_dbg[0] = 9;
        applyStimulus();
        check("byp.data1", ifa.data1, 32'hA5A5A5A5);
        check("byp.data2", ifa.data2, 32'hA5A5A5A5);
        check("byp.dbg", ifa.dbg_data, 32'h0);
        cycle();
        in_we[0] = 0;
        cycle();

        // Fill 1..31, sweep, drop a write mid-sweep, ignore a second request.
        for (int i = 1; i < 32; i++) begin
            in_we[0] = 1; in_wr[0] = i; in_wd[0] = i; in_r1[0] = i; in_r2[0] = i - 1;
            cycle();
        end
        in_we[0] = 0; in_clr[0] = 1;
        cycle();
        in_clr[0] = 0;
        busy_cnt = 0;
        for (int n = 0; n < 34; n++) begin
            in_we[0] = (n == 5); in_wr[0] = 3; in_wd[0] = 32'h77;
            in_clr[0] = (n == 7);
            in_r1[0] = 3; in_r2[0] = 31 - (n % 32); in_dbg[0] = n % 32;
            applyStimulus();
            checkOutput();
            if (ifa.busy === 1'b1) busy_cnt++;
            tick();
        end
        check("clr.busy_cycles", 32'(busy_cnt), 32'd32);
        in_we[0] = 0; in_clr[0] = 0;
        read_all_zero(0, "clr.all_zero");

        // Reset in the middle of a sweep.
        for (int i = 1; i < 32; i++) begin
            in_we[0] = 1; in_wr[0] = i; in_wd[0] = $urandom;
            cycle();
        end
        in_we[0] = 0; in_clr[0] = 1;
        cycle();
        in_clr[0] = 0;
        for (int n = 0; n < 10; n++) cycle();
        reset = 1'b1;
        model_reset();
        applyStimulus();
        check("abort.busy", {31'b0, ifa.busy}, 32'h0);
        checkOutput();
        @(negedge clock);
        reset = 1'b0;
        read_all_zero(0, "abort.all_zero");
        in_we[0] = 1; in_wr[0] = 4; in_wd[0] = 32'h55;
        cycle();
        in_we[0] = 0; in_r1[0] = 4;
        applyStimulus();
        check("abort.wr4", ifa.data1, 32'h55);
        cycle();

        // Small instance: entry 0 is ordinary, sweep lasts 8 cycles.
        in_we[1] = 1; in_wr[1] = 0; in_wd[1] = 32'hBEEF; in_r1[1] = 0;
        cycle();
        in_we[1] = 0;
        applyStimulus();
        check("b.reg0", {16'b0, ifb.data1}, 32'hBEEF);
        in_clr[1] = 1;
        cycle();
        in_clr[1] = 0;
        busy_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            in_r1[1] = n % 8; in_dbg[1] = (n + 3) % 8;
            applyStimulus();
            checkOutput();
            if (ifb.busy === 1'b1) busy_cnt++;
            tick();
        end
        check("b.busy_cycles", 32'(busy_cnt), 32'd8);
        read_all_zero(1, "b.all_zero");

        // Randomized traffic with occasional sweeps on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 2; u++) begin
                in_we[u]  = $urandom_range(0, 1) != 0;
                in_wr[u]  = $urandom_range(0, depth[u] - 1);
                in_wd[u]  = (u == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF);
                in_r1[u]  = ($urandom_range(0, 3) == 0) ? in_wr[u] : $urandom_range(0, depth[u] - 1);
                in_r2[u]  = ($urandom_range(0, 3) == 0) ? in_wr[u] : $urandom_range(0, depth[u] - 1);
                in_dbg[u] = ($urandom_range(0, 3) == 0) ? in_wr[u] : $urandom_range(0, depth[u] - 1);
                in_clr[u] = $urandom_range(0, 39) == 0;
            end
            cycle();
        end

        idle_inputs();
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
